// File: rtl/cpu_run_control_pkg.sv
// Shared definitions for the CPU run/step/breakpoint sequencer.
package cpu_run_control_pkg;

    // Default width of PC and BRK_ADDR.
    localparam int unsigned PC_W_DFLT = 14;

    // Run-state encodings, also exported on RUN_STATE for the debug overlay.
    typedef enum logic [1:0] {
        RS_RUN    = 2'b00,
        RS_PAUSED = 2'b01,
        RS_BRK    = 2'b10
    } run_state_e;

endpackage

// File: rtl/cpu_run_control_sync.sv
// Button/level synchronizer with a one-cycle rising-edge pulse.
module btn_sync_edge #(
    parameter int unsigned SYNC_STG = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_i,
    output logic level_o,
    output logic rise_o
);

    logic [SYNC_STG-1:0] sync_q;
    logic [SYNC_STG-1:0] sync_d;
    logic                prev_q;

    // Shift the raw input in at bit 0; the top bit is the synchronized level.
    always_comb begin
        sync_d = SYNC_STG'({sync_q, btn_i});
    end

    // Synchronizer chain and previous-level flop for edge detection.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= sync_q[SYNC_STG-1];
        end
    end

    assign level_o = sync_q[SYNC_STG-1];
    assign rise_o  = sync_q[SYNC_STG-1] & ~prev_q;

endmodule

// File: rtl/cpu_run_control.sv
// Run/step/breakpoint sequencer: divides CLK into a CPU_EN strobe and gates it
// for free-run, pause, single-step and PC-breakpoint halt.
module cpu_run_control
    import cpu_run_control_pkg::*;
#(
    parameter int unsigned DIV_LIMIT = 500,
    parameter int unsigned PC_W      = PC_W_DFLT,
    parameter int unsigned SYNC_STG  = 2
) (
    input  logic            CLK,
    input  logic            CLR,
    input  logic            PAUSE,
    input  logic            STEP,
    input  logic            BRK_EN,
    input  logic [PC_W-1:0] BRK_ADDR,
    input  logic [PC_W-1:0] PC,
    output logic            CPU_EN,
    output logic [1:0]      RUN_STATE,
    output logic            HALTED,
    output logic [31:0]     INSTR_CNT
);

    localparam int unsigned CNT_W = $clog2(DIV_LIMIT + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick;
    run_state_e       state_q, state_d;
    logic             step_pend_q, step_pend_d;
    logic             cpu_en_q, cpu_en_d;
    logic [31:0]      instr_cnt_q, instr_cnt_d;
    logic             pause_s;
    logic             pause_rise_unused;
    logic             step_edge;
    logic             brk_hit;
    logic             issue;
    logic             step_clr;

    btn_sync_edge #(.SYNC_STG(SYNC_STG)) u_pause_sync (
        .clk_i  (CLK),
        .rst_ni (CLR),
        .btn_i  (PAUSE),
        .level_o(pause_s),
        .rise_o (pause_rise_unused)
    );

    btn_sync_edge #(.SYNC_STG(SYNC_STG)) u_step_sync (
        .clk_i  (CLK),
        .rst_ni (CLR),
        .btn_i  (STEP),
        .level_o(),
        .rise_o (step_edge)
    );

    assign tick    = (cnt_q == CNT_W'(DIV_LIMIT));
    assign brk_hit = BRK_EN && (PC == BRK_ADDR);

    // Free-running divider next state; never re-phased by the FSM.
    always_comb begin
        cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
    end

    // Run FSM next state, pulse issue and step bookkeeping.
    // A step edge arriving on the consuming tick is only latched, so it is
    // served at the following tick; a press landing while a step is being
    // consumed is absorbed by the single pending bit.
    always_comb begin
        state_d  = state_q;
        issue    = 1'b0;
        step_clr = 1'b0;
        unique case (state_q)
            RS_RUN: begin
                if (pause_s) begin
                    state_d = RS_PAUSED;
                end else if (tick) begin
                    if (brk_hit) state_d = RS_BRK;
                    else         issue   = 1'b1;
                end
            end
            RS_PAUSED: begin
                if (!pause_s) begin
                    state_d = RS_RUN;
                end else if (tick && step_pend_q) begin
                    issue    = 1'b1;
                    step_clr = 1'b1;
                end
            end
            RS_BRK: begin
                if (tick && step_pend_q) begin
                    issue    = 1'b1;
                    step_clr = 1'b1;
                    state_d  = pause_s ? RS_PAUSED : RS_RUN;
                end
            end
            default: state_d = RS_RUN;
        endcase
        step_pend_d = step_clr ? 1'b0 : (step_pend_q | step_edge);
        cpu_en_d    = issue;
        instr_cnt_d = issue ? instr_cnt_q + 32'd1 : instr_cnt_q;
    end

    // Divider, FSM state, pending step, strobe and instruction counter.
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            cnt_q       <= '0;
            state_q     <= RS_RUN;
            step_pend_q <= 1'b0;
            cpu_en_q    <= 1'b0;
            instr_cnt_q <= '0;
        end else begin
            cnt_q       <= cnt_d;
            state_q     <= state_d;
            step_pend_q <= step_pend_d;
            cpu_en_q    <= cpu_en_d;
            instr_cnt_q <= instr_cnt_d;
        end
    end

    assign CPU_EN    = cpu_en_q;
    assign RUN_STATE = state_q;
    assign HALTED    = (state_q != RS_RUN);
    assign INSTR_CNT = instr_cnt_q;

endmodule

// File: tb/tb_cpu_run_control.sv
// Scoreboard bench for cpu_run_control with DIV_LIMIT=4, SYNC_STG=2.
module tb_cpu_run_control;

    logic        clk = 1'b0;
    logic        CLR = 1'b1;
    logic        PAUSE = 1'b0;
    logic        STEP = 1'b0;
    logic        BRK_EN = 1'b0;
    logic [13:0] BRK_ADDR = '0;
    logic [13:0] PC = '0;
    logic        CPU_EN;
    logic [1:0]  RUN_STATE;
    logic        HALTED;
    logic [31:0] INSTR_CNT;

    typedef struct {
        int unsigned edge_n;
        logic [31:0] cnt;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        mon_e;
    int unsigned n_checks = 0;
    int unsigned n_err    = 0;
    int unsigned ecnt;
    logic [31:0] exp_cnt = '0;

    cpu_run_control #(.DIV_LIMIT(4), .PC_W(14), .SYNC_STG(2)) dut (
        .CLK      (clk),
        .CLR      (CLR),
        .PAUSE    (PAUSE),
        .STEP     (STEP),
        .BRK_EN   (BRK_EN),
        .BRK_ADDR (BRK_ADDR),
        .PC       (PC),
        .CPU_EN   (CPU_EN),
        .RUN_STATE(RUN_STATE),
        .HALTED   (HALTED),
        .INSTR_CNT(INSTR_CNT)
    );

    always #5 clk = ~clk;

    // Rising edges since reset release; pulses are expected at known edges.
    always @(posedge clk or negedge CLR) begin
        if (!CLR) ecnt <= 0;
        else      ecnt <= ecnt + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", tag, got, exp, ecnt);
        end
    endtask

    task automatic push_pulse(input int unsigned e);
        exp_cnt = exp_cnt + 32'd1;
        sb_q.push_back('{e, exp_cnt});
    endtask

    task automatic goto_edge(input int unsigned n);
        int unsigned guard = 0;
        while (ecnt < n && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        if (ecnt != n) check_eq("goto_edge_timeout", ecnt, n);
    endtask

    // Every CPU_EN pulse must match the next scoreboard entry.
    always @(negedge clk) begin
        if (CLR && CPU_EN) begin
            if (sb_q.size() == 0) begin
                check_eq("pulse_unexpected", ecnt, 32'hFFFF_FFFF);
            end else begin
                mon_e = sb_q.pop_front();
                check_eq("pulse_edge", ecnt, mon_e.edge_n);
                check_eq("pulse_cnt", INSTR_CNT, mon_e.cnt);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #1 CLR = 1'b0;
        #2;
        check_eq("rst_cpu_en", CPU_EN, 0);
        check_eq("rst_cnt", INSTR_CNT, 0);
        check_eq("rst_state", RUN_STATE, 0);
        check_eq("rst_halted", HALTED, 0);

        // 1: free run
        @(negedge clk);
        @(negedge clk);
        CLR = 1'b1;
        push_pulse(5); push_pulse(10); push_pulse(15); push_pulse(20);
        goto_edge(20);
        check_eq("run_cnt20", INSTR_CNT, 4);
        check_eq("run_state", RUN_STATE, 0);

        // 2: pause, single step, double press
        PAUSE = 1'b1;
        goto_edge(23);
        check_eq("pause_state", RUN_STATE, 1);
        check_eq("pause_halted", HALTED, 1);
        goto_edge(30);
        check_eq("pause_no_pulse", INSTR_CNT, 4);
        STEP = 1'b1;
        push_pulse(35);
        goto_edge(33); STEP = 1'b0;
        goto_edge(38); STEP = 1'b1;
        goto_edge(39); STEP = 1'b0;
        goto_edge(40); STEP = 1'b1;
        goto_edge(41); STEP = 1'b0;
        push_pulse(45);
        goto_edge(52);
        check_eq("two_press_cnt", INSTR_CNT, 6);

        // 3: breakpoint in run, step past it
        PAUSE = 1'b0; BRK_EN = 1'b1; BRK_ADDR = 14'h0010; PC = 14'h000F;
        push_pulse(60);
        goto_edge(60); PC = 14'h0010;
        goto_edge(65);
        check_eq("brk_state", RUN_STATE, 2);
        check_eq("brk_halted", HALTED, 1);
        goto_edge(72);
        check_eq("brk_no_pulse", INSTR_CNT, 7);
        STEP = 1'b1;
        push_pulse(80);
        goto_edge(74); STEP = 1'b0;
        goto_edge(80);
        check_eq("brk_step_run", RUN_STATE, 0);
        PC = 14'h0011;
        push_pulse(85);

        // 4: breakpoint, step while paused
        goto_edge(85); PC = 14'h0010;
        goto_edge(90);
        check_eq("brk2_state", RUN_STATE, 2);
        PAUSE = 1'b1; BRK_EN = 1'b0;
        goto_edge(91); STEP = 1'b1;
        push_pulse(95);
        goto_edge(93); STEP = 1'b0;
        goto_edge(94);
        check_eq("brk_en_clear_hold", RUN_STATE, 2);
        goto_edge(95);
        check_eq("brk_step_paused", RUN_STATE, 1);

        // 5: step edge on the tick cycle waits for the next tick
        goto_edge(97); STEP = 1'b1;
        push_pulse(105);
        goto_edge(99); STEP = 1'b0;
        goto_edge(102);
        check_eq("edge_on_tick_wait", INSTR_CNT, 10);

        // 6: async reset with a pulse in flight
        goto_edge(105); PAUSE = 1'b0;
        push_pulse(110);
        goto_edge(110);
        check_eq("inflight_pre", CPU_EN, 1);
        #2 CLR = 1'b0;
        #1;
        check_eq("mid_rst_cpu_en", CPU_EN, 0);
        check_eq("mid_rst_cnt", INSTR_CNT, 0);
        check_eq("mid_rst_state", RUN_STATE, 0);
        @(negedge clk);
        @(negedge clk);
        CLR = 1'b1;
        exp_cnt = '0;
        push_pulse(5);
        goto_edge(7);
        check_eq("post_rst_cnt", INSTR_CNT, 1);
        check_eq("sb_empty", sb_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
